mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of a single-port reg_mem (synchronous write, addr/data_in/wen/data_out).
- Requesters 0 and 1 each issue one read or write at a time through a req/gnt handshake. The arbiter drives the memory port, waits the memory read latency, and returns read data with a one-cycle valid pulse.

Parameters:
- DATA_WIDTH, 8, width of memory data word.
- ADDR_BITS, 12, width of memory address.
- READ_LAT, 1, number of cycles after mem_addr is driven before mem_dout is valid; legal range 0..7.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- r0_req  input  1  requester 0 has an access pending; held with fields stable until r0_gnt.
- r0_we  input  1  1 = write, 0 = read.
- r0_addr  input  ADDR_BITS  access address.
- r0_wdata  input  DATA_WIDTH  write data.
- r0_gnt  output  1  one-cycle pulse: request accepted.
- r0_rvalid  output  1  one-cycle pulse: r0_rdata valid.
- r0_rdata  output  DATA_WIDTH  read data, held until the next r0 read completes.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: identical to the r0 ports, for requester 1.
- mem_addr  output  ADDR_BITS  to reg_mem addr.
- mem_din  output  DATA_WIDTH  to reg_mem data_in.
- mem_wen  output  1  to reg_mem wen.
- mem_dout  input  DATA_WIDTH  from reg_mem data_out.
- busy  output  1  high whenever state != IDLE.

Behaviour:

Reset (rst=1 at an edge):
- state=IDLE; all outputs 0 (gnt, rvalid, rdata, mem_addr, mem_din, mem_wen, busy); last_gnt=1, so r0 wins the first tie.
- Reset mid-operation aborts the access: no rvalid is issued, and mem_wen is 0 from the next cycle.

FSM states: IDLE, WRITE, READ_WAIT.

IDLE (grant decision on the edge at the end of cycle t):
- If exactly one req is high, that requester is selected.
- If both are high, the requester != last_gnt is selected.
- On that edge: latch the selected addr into mem_addr and wdata into mem_din, set that requester's gnt=1, update last_gnt.
  - we=1: set mem_wen=1, go to WRITE.
  - we=0: set mem_wen=0, load the wait counter with READ_LAT, go to READ_WAIT.
- If no req is high, stay in IDLE; mem_wen=0.

WRITE (cycle t+1):
- gnt and mem_wen are high for exactly this cycle; the memory captures the write at the end of t+1.
- Next state is IDLE; mem_wen and gnt drop.
- Write throughput: one write per 2 cycles.

READ_WAIT:
- gnt is high only in the first READ_WAIT cycle.
- mem_addr is held stable throughout; mem_wen stays 0.
- While the counter is nonzero, decrement it.
- When the counter is 0: capture mem_dout into the owner's rdata, pulse the owner's rvalid in the following cycle, go to IDLE.
- Read latency from grant decision to rvalid: READ_LAT+2 cycles. With READ_LAT=1, req is sampled at edge t and rvalid is high in cycle t+3.

Rules:
- rvalid may coincide with the IDLE cycle that samples a new request; back-to-back accesses are allowed.
- A requester must drop req in the cycle after it sees gnt. The arbiter never samples req outside IDLE, so a lingering req is treated as a new request.
- The non-owner's rdata and rvalid are untouched.
- mem_addr and mem_din hold their last values in IDLE; only mem_wen gates writes.
- Counter width is 3 bits; no wrap occurs because of the READ_LAT range.

Test Plan:
- Reset: assert rst for 2 cycles mid-read (r0 read addr 5) -> busy=0, mem_wen=0, no r0_rvalid, all rdata=0.
- Single write then read: r0 writes 0x2A to addr 0x010, then reads addr 0x010 -> one r0_gnt pulse per access; mem_wen high exactly 1 cycle; r0_rvalid 3 cycles after read req sampled; r0_rdata=0x2A.
- Contention: r0 and r1 both request reads in the same cycle after reset (addr 1 holding 0x11, addr 2 holding 0x22) -> r0 granted first, r1 next; r0_rdata=0x11, r1_rdata=0x22; no overlap on the memory port.
- Round-robin fairness: both hold req continuously for 8 writes each (r0 writes i to addr i, r1 writes 0x80+i to addr 0x100+i, i=1..8) -> gnts strictly alternate r0,r1,r0,...; readback of all 16 addresses matches.
- Sweep writes: r1 writes values 1..32 to addresses 1..32, then reads them back -> every rvalid carries the matching value; r0_rvalid never pulses.
- Latency parameter: instantiate with READ_LAT=0 and READ_LAT=3; r0 reads addr 7 holding 0x5C -> rvalid at +2 and +5 cycles respectively; data 0x5C.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of every signal between two requesters, the
//               mem_arbiter, and a single-port reg_mem.
//               slave  : arbiter view. It takes requests and mem_dout, and
//                        drives gnt/rvalid/rdata, the memory port and busy.
//               master : environment view (requesters plus memory model).
//               Signals per requester n (0/1):
//                 rn_req, rn_we, rn_addr, rn_wdata  -> arbiter
//                 rn_gnt, rn_rvalid, rn_rdata       <- arbiter
//               Memory side:
//                 mem_addr, mem_din, mem_wen        <- arbiter
//                 mem_dout                          -> arbiter
//                 busy                              <- arbiter
// Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 12
);
  // Requester 0
  logic                  r0_req;
  logic                  r0_we;
  logic [ADDR_BITS-1:0]  r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic                  r0_gnt;
  logic                  r0_rvalid;
  logic [DATA_WIDTH-1:0] r0_rdata;

  // Requester 1
  logic                  r1_req;
  logic                  r1_we;
  logic [ADDR_BITS-1:0]  r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_gnt;
  logic                  r1_rvalid;
  logic [DATA_WIDTH-1:0] r1_rdata;

  // Memory port and status
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_addr, mem_din, mem_wen,
    input  mem_dout,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_addr, mem_din, mem_wen,
    output mem_dout,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter and access sequencer in front
//               of a single-port reg_mem. Each requester issues one read or
//               write at a time through a req/gnt handshake. Writes take two
//               cycles (decision + write strobe). Reads wait READ_LAT cycles
//               for the memory, then return data with a one-cycle rvalid.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - mem_arbiter_if.slave (requesters, memory port, busy)
// Parameters  : DATA_WIDTH - memory word width
//               ADDR_BITS  - memory address width
//               READ_LAT   - cycles from mem_addr driven to mem_dout valid,
//                            legal range 0..7
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 12,
  parameter int READ_LAT   = 1
) (
  input  wire           clk,
  input  wire           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2
  } state_t;

  // The wait counter is three bits wide. READ_LAT is capped at 7, so the
  // load value always fits and the countdown never wraps.
  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t                state_q;
  logic [2:0]            cnt_q;
  logic                  last_gnt_q;   // 0 = r0 granted last, 1 = r1
  logic                  owner_q;      // requester that owns the current read

  logic                  r0_gnt_q;
  logic                  r0_rvalid_q;
  logic [DATA_WIDTH-1:0] r0_rdata_q;
  logic                  r1_gnt_q;
  logic                  r1_rvalid_q;
  logic [DATA_WIDTH-1:0] r1_rdata_q;

  logic [ADDR_BITS-1:0]  mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_din_q;
  logic                  mem_wen_q;
  logic                  busy_q;

  // --------------------------------------------------------------------------
  // Arbitration. Only consumed in IDLE. On a tie the requester that was not
  // granted last wins, which gives strict alternation under continuous load.
  // --------------------------------------------------------------------------
  logic                  req_any;
  logic                  pick_r1;
  logic                  sel_we;
  logic [ADDR_BITS-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_comb begin
    req_any = bus.r0_req | bus.r1_req;
    if (bus.r0_req && bus.r1_req) begin
      pick_r1 = ~last_gnt_q;
    end else begin
      pick_r1 = bus.r1_req;
    end
    sel_we    = pick_r1 ? bus.r1_we    : bus.r0_we;
    sel_addr  = pick_r1 ? bus.r1_addr  : bus.r0_addr;
    sel_wdata = pick_r1 ? bus.r1_wdata : bus.r0_wdata;
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      last_gnt_q  <= 1'b1;         // makes r0 win the first tie
      owner_q     <= 1'b0;
      r0_gnt_q    <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_gnt_q    <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r1_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_wen_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // gnt and rvalid are single-cycle pulses. They are cleared by default
      // and only set on the edge that starts the pulse.
      r0_gnt_q    <= 1'b0;
      r1_gnt_q    <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          mem_wen_q <= 1'b0;
          busy_q    <= 1'b0;
          if (req_any) begin
            // mem_din is loaded on reads as well. Only mem_wen qualifies a
            // write, so the value is harmless.
            mem_addr_q <= sel_addr;
            mem_din_q  <= sel_wdata;
            owner_q    <= pick_r1;
            last_gnt_q <= pick_r1;
            busy_q     <= 1'b1;
            if (pick_r1) begin
              r1_gnt_q <= 1'b1;
            end else begin
              r0_gnt_q <= 1'b1;
            end
            if (sel_we) begin
              mem_wen_q <= 1'b1;
              state_q   <= WRITE;
            end else begin
              cnt_q     <= LAT_LOAD;
              state_q   <= READ_WAIT;
            end
          end
        end

        WRITE: begin
          // The memory captures the write at the end of this cycle.
          mem_wen_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end

        READ_WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            // mem_dout is valid now. Only the owner's rdata is updated, so
            // the other requester's last read result stays intact.
            if (owner_q) begin
              r1_rdata_q  <= bus.mem_dout;
              r1_rvalid_q <= 1'b1;
            end else begin
              r0_rdata_q  <= bus.mem_dout;
              r0_rvalid_q <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          mem_wen_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.r0_gnt    = r0_gnt_q;
  assign bus.r0_rvalid = r0_rvalid_q;
  assign bus.r0_rdata  = r0_rdata_q;
  assign bus.r1_gnt    = r1_gnt_q;
  assign bus.r1_rvalid = r1_rvalid_q;
  assign bus.r1_rdata  = r1_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed bench for mem_arbiter. Three lanes, each with its own
//               interface, DUT and reg_mem model:
//                 lane 0 : READ_LAT=1 (main lane)
//                 lane 1 : READ_LAT=0
//                 lane 2 : READ_LAT=3
//               Inputs are driven and outputs are sampled on the falling
//               clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus, indexed [lane][port]
  logic [2:0][1:0]       req_s   = '0;
  logic [2:0][1:0]       we_s    = '0;
  logic [2:0][1:0][11:0] addr_s  = '0;
  logic [2:0][1:0][7:0]  wd_s    = '0;

  // Observation, indexed [lane][port] or [lane]
  wire  [2:0][1:0]       gnt_w;
  wire  [2:0][1:0]       rv_w;
  wire  [2:0][1:0][7:0]  rd_w;
  wire  [2:0]            wen_w;
  wire  [2:0]            busy_w;
  wire  [2:0][11:0]      maddr_w;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    mem_arbiter_if #(.DATA_WIDTH(8), .ADDR_BITS(12)) bus ();

    mem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(12), .READ_LAT(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.r0_req   = req_s[g][0];
    assign bus.r0_we    = we_s[g][0];
    assign bus.r0_addr  = addr_s[g][0];
    assign bus.r0_wdata = wd_s[g][0];
    assign bus.r1_req   = req_s[g][1];
    assign bus.r1_we    = we_s[g][1];
    assign bus.r1_addr  = addr_s[g][1];
    assign bus.r1_wdata = wd_s[g][1];

    assign gnt_w[g][0]  = bus.r0_gnt;
    assign gnt_w[g][1]  = bus.r1_gnt;
    assign rv_w[g][0]   = bus.r0_rvalid;
    assign rv_w[g][1]   = bus.r1_rvalid;
    assign rd_w[g][0]   = bus.r0_rdata;
    assign rd_w[g][1]   = bus.r1_rdata;
    assign wen_w[g]     = bus.mem_wen;
    assign busy_w[g]    = bus.busy;
    assign maddr_w[g]   = bus.mem_addr;

    // reg_mem model: synchronous write, read data delayed L cycles from addr
    logic [7:0] mem [4096];
    logic [7:0] rd_now, p1, p2, p3;
    assign rd_now = mem[bus.mem_addr];
    always @(posedge clk) begin
      if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_din;
      p1 <= rd_now;
      p2 <= p1;
      p3 <= p2;
    end
    assign bus.mem_dout = (L == 0) ? rd_now : (L == 1) ? p1 : (L == 2) ? p2 : p3;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One access on lane d, port p, started with the DUT idle. Cycle numbers
  // count falling edges after the request is raised. Grant comes at cycle 1.
  // For a read, rvalid arrives at cycle erv.
  task automatic access(input int d, input int p, input logic we,
                        input logic [11:0] a, input logic [7:0] wd,
                        input logic [7:0] erd, input int erv, input string tag);
    int gl, gc, vl, vc, wc, ov;
    logic [7:0] rd;
    req_s[d][p] = 1'b1; we_s[d][p] = we; addr_s[d][p] = a; wd_s[d][p] = wd;
    gl = -1; gc = 0; vl = -1; vc = 0; wc = 0; ov = 0; rd = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (wen_w[d]) wc++;
      if (gnt_w[d][p]) begin
        gc++;
        if (gl < 0) gl = k;
        req_s[d][p] = 1'b0;
      end
      if (rv_w[d][p]) begin
        vc++;
        if (vl < 0) begin vl = k; rd = rd_w[d][p]; end
      end
      if (rv_w[d][1-p] || gnt_w[d][1-p]) ov++;
    end
    check({tag, ".gnt_cycle"}, 32'(gl), 32'd1);
    check({tag, ".gnt_pulses"}, 32'(gc), 32'd1);
    if (we) begin
      check({tag, ".wen_cycles"}, 32'(wc), 32'd1);
      check({tag, ".rvalid_pulses"}, 32'(vc), 32'd0);
    end else begin
      check({tag, ".rvalid_cycle"}, 32'(vl), 32'(erv));
      check({tag, ".rvalid_pulses"}, 32'(vc), 32'd1);
      check({tag, ".rdata"}, 32'(rd), 32'(erd));
      check({tag, ".rdata_held"}, 32'(rd_w[d][p]), 32'(erd));
      check({tag, ".wen_cycles"}, 32'(wc), 32'd0);
    end
    check({tag, ".other_port_quiet"}, 32'(ov), 32'd0);
  endtask

  initial begin
    int rvc, g0, g1, v0, v1, n, i0, i1, both;
    logic [7:0] rd0, rd1;
    int ord [16];

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst.busy%0d", d), 32'(busy_w[d]), 32'd0);
      check($sformatf("rst.wen%0d", d), 32'(wen_w[d]), 32'd0);
      check($sformatf("rst.maddr%0d", d), 32'(maddr_w[d]), 32'd0);
    end
    check("rst.gnt", 32'(gnt_w[0]), 32'd0);
    check("rst.rvalid", 32'(rv_w[0]), 32'd0);
    check("rst.rdata0", 32'(rd_w[0][0]), 32'd0);
    check("rst.rdata1", 32'(rd_w[0][1]), 32'd0);
    rst = 1'b0;

    // ---------------- reset mid-read ----------------
    @(negedge clk);
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b0; addr_s[0][0] = 12'd5;
    @(negedge clk);
    check("midrst.gnt", 32'(gnt_w[0][0]), 32'd1);
    check("midrst.busy_before", 32'(busy_w[0]), 32'd1);
    req_s[0][0] = 1'b0;
    rst = 1'b1;
    rvc = 0;
    repeat (2) begin
      @(negedge clk);
      if (rv_w[0][0]) rvc++;
      check("midrst.busy", 32'(busy_w[0]), 32'd0);
      check("midrst.wen", 32'(wen_w[0]), 32'd0);
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rv_w[0][0]) rvc++;
    end
    check("midrst.no_rvalid", 32'(rvc), 32'd0);
    check("midrst.rdata0", 32'(rd_w[0][0]), 32'd0);
    check("midrst.rdata1", 32'(rd_w[0][1]), 32'd0);

    // ---------------- single write then read ----------------
    access(0, 0, 1'b1, 12'h010, 8'h2A, 8'h00, 0, "wr010");
    access(0, 0, 1'b0, 12'h010, 8'h00, 8'h2A, 3, "rd010");

    // ---------------- contention after reset ----------------
    access(0, 0, 1'b1, 12'd1, 8'h11, 8'h00, 0, "pre1");
    access(0, 1, 1'b1, 12'd2, 8'h22, 8'h00, 0, "pre2");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b0; addr_s[0][0] = 12'd1;
    req_s[0][1] = 1'b1; we_s[0][1] = 1'b0; addr_s[0][1] = 12'd2;
    g0 = -1; g1 = -1; v0 = -1; v1 = -1; rd0 = '0; rd1 = '0; both = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (gnt_w[0][0] && gnt_w[0][1]) both++;
      if (gnt_w[0][0] && g0 < 0) begin g0 = k; req_s[0][0] = 1'b0; end
      if (gnt_w[0][1] && g1 < 0) begin g1 = k; req_s[0][1] = 1'b0; end
      if (rv_w[0][0] && v0 < 0) begin v0 = k; rd0 = rd_w[0][0]; end
      if (rv_w[0][1] && v1 < 0) begin v1 = k; rd1 = rd_w[0][1]; end
    end
    check("cont.r0_gnt_cycle", 32'(g0), 32'd1);
    check("cont.r0_rvalid_cycle", 32'(v0), 32'd3);
    check("cont.r1_gnt_cycle", 32'(g1), 32'd4);
    check("cont.r1_rvalid_cycle", 32'(v1), 32'd6);
    check("cont.r0_rdata", 32'(rd0), 32'h11);
    check("cont.r1_rdata", 32'(rd1), 32'h22);
    check("cont.no_double_gnt", 32'(both), 32'd0);

    // ---------------- round-robin fairness ----------------
    i0 = 1; i1 = 1; n = 0; both = 0;
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b1; addr_s[0][0] = 12'd1;      wd_s[0][0] = 8'd1;
    req_s[0][1] = 1'b1; we_s[0][1] = 1'b1; addr_s[0][1] = 12'h101;    wd_s[0][1] = 8'h81;
    for (int k = 0; k < 80 && n < 16; k++) begin
      @(negedge clk);
      if (gnt_w[0][0] && gnt_w[0][1]) both++;
      if (gnt_w[0][0]) begin
        if (n < 16) ord[n] = 0;
        n++; i0++;
        if (i0 > 8) req_s[0][0] = 1'b0;
        else begin addr_s[0][0] = 12'(i0); wd_s[0][0] = 8'(i0); end
      end
      if (gnt_w[0][1]) begin
        if (n < 16) ord[n] = 1;
        n++; i1++;
        if (i1 > 8) req_s[0][1] = 1'b0;
        else begin addr_s[0][1] = 12'(12'h100 + i1); wd_s[0][1] = 8'(8'h80 + i1); end
      end
    end
    req_s[0] = '0;
    repeat (2) @(negedge clk);
    check("rr.grant_count", 32'(n), 32'd16);
    check("rr.no_double_gnt", 32'(both), 32'd0);
    for (int j = 0; j < 16; j++) check($sformatf("rr.order%0d", j), 32'(ord[j]), 32'(j % 2));
    for (int i = 1; i <= 8; i++) begin
      access(0, 0, 1'b0, 12'(i), 8'h00, 8'(i), 3, $sformatf("rr.rd0_%0d", i));
      access(0, 1, 1'b0, 12'(12'h100 + i), 8'h00, 8'(8'h80 + i), 3, $sformatf("rr.rd1_%0d", i));
    end

    // ---------------- r1 sweep ----------------
    for (int i = 1; i <= 32; i++)
      access(0, 1, 1'b1, 12'(i), 8'(i), 8'h00, 0, $sformatf("sw.wr%0d", i));
    for (int i = 1; i <= 32; i++)
      access(0, 1, 1'b0, 12'(i), 8'h00, 8'(i), 3, $sformatf("sw.rd%0d", i));

    // ---------------- READ_LAT = 0 and 3 ----------------
    access(1, 0, 1'b1, 12'd7, 8'h5C, 8'h00, 0, "lat0.wr");
    access(1, 0, 1'b0, 12'd7, 8'h00, 8'h5C, 2, "lat0.rd");
    access(2, 0, 1'b1, 12'd7, 8'h5C, 8'h00, 0, "lat3.wr");
    access(2, 0, 1'b0, 12'd7, 8'h00, 8'h5C, 5, "lat3.rd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
